// File: rtl/trap_pkg.sv
// Shared encodings for the trap sequencer: CSR op codes, interrupt causes and FSM states.
package trap_pkg;

  localparam logic [2:0] CSR_OP_EXCEPTION = 3'b000;
  localparam logic [2:0] CSR_OP_MRET      = 3'b001;

  localparam logic [4:0] CAUSE_M_EXT_INT  = 5'b11011;
  localparam logic [4:0] CAUSE_M_SW_INT   = 5'b10011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_REDIRECT,
    ST_ERROR
  } state_t;

  function automatic logic [11:0] cause_to_addr(input logic [4:0] cause);
    return {7'b0, cause};
  endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// CSR op handshake between the trap sequencer (master) and the CSR unit (slave).
interface trap_sequencer_if;
  logic        csr_available;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr_exception;
  logic [31:0] csr_write_value;
  logic [31:0] csr_read_value;
  logic        csr_busy;
  logic        csr_fault;

  modport master (
    output csr_available, csr_op, csr_addr_exception, csr_write_value,
    input  csr_read_value, csr_busy, csr_fault
  );

  modport slave (
    input  csr_available, csr_op, csr_addr_exception, csr_write_value,
    output csr_read_value, csr_busy, csr_fault
  );
endinterface

// File: rtl/trap_priority_arbiter.sv
// Combinational select among exception, external/software interrupt and MRET,
// producing the CSR op and 5-bit cause of the winner.
module trap_priority_arbiter
  import trap_pkg::*;
(
  input  logic       exc_req,
  input  logic [3:0] exc_code,
  input  logic       ext_int_pending,
  input  logic       sw_int_pending,
  input  logic       int_boundary,
  input  logic       mret_req,
  output logic       take,
  output logic [2:0] op,
  output logic [4:0] cause
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    take  = 1'b1;
    op    = CSR_OP_EXCEPTION;
    cause = 5'b0;
    if (exc_req) begin
      cause = {1'b0, exc_code};
    end else if (ext_int_pending && int_boundary) begin
      cause = CAUSE_M_EXT_INT;
    end else if (sw_int_pending && int_boundary) begin
      cause = CAUSE_M_SW_INT;
    end else if (mret_req) begin
      op = CSR_OP_MRET;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap/MRET sequencer: arbitrates requests, issues one CSR op, waits for it, redirects the PC.
// Optional saturating trap counter enabled by defining TRAP_COUNT_EN.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   exc_req,
  input  logic [3:0]             exc_code,
  input  logic [31:0]            trap_pc,
  input  logic                   mret_req,
  input  logic                   int_boundary,
  input  logic                   ext_int_pending,
  input  logic                   sw_int_pending,
  trap_sequencer_if.master       csr,
  output logic                   ready,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   seq_error,
  output logic [COUNT_WIDTH-1:0] trap_count
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, next_state;
  logic              take;
  logic [2:0]        arb_op;
  logic [4:0]        arb_cause;
  logic [2:0]        op_q;
  logic [11:0]       addr_q;
  logic [31:0]       value_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_hit;
  logic              accept;

  trap_priority_arbiter u_arb (
    .exc_req         (exc_req),
    .exc_code        (exc_code),
    .ext_int_pending (ext_int_pending),
    .sw_int_pending  (sw_int_pending),
    .int_boundary    (int_boundary),
    .mret_req        (mret_req),
    .take            (take),
    .op              (arb_op),
    .cause           (arb_cause)
  );

  assign accept      = (state == ST_IDLE) && take;
  assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (take) next_state = ST_ISSUE;
      ST_ISSUE:    if (csr.csr_fault)      next_state = ST_ERROR;
                   else if (csr.csr_busy)  next_state = ST_WAIT;
                   else if (timeout_hit)   next_state = ST_ERROR;
      ST_WAIT:     if (csr.csr_fault)      next_state = ST_ERROR;
                   else if (!csr.csr_busy) next_state = ST_REDIRECT;
                   else if (timeout_hit)   next_state = ST_ERROR;
      ST_REDIRECT: next_state = ST_IDLE;
      ST_ERROR:    next_state = ST_ERROR;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    csr.csr_available = (state == ST_ISSUE) || (state == ST_WAIT);
    ready             = (state == ST_IDLE);
    redirect_valid    = (state == ST_REDIRECT);
    seq_error         = (state == ST_ERROR);
  end

  // Op fields are held from accept until the next accept, covering ISSUE through REDIRECT.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: datapath registers are reset too, so every output reads 0 out of reset.
    if (!reset_n) begin
      op_q        <= CSR_OP_EXCEPTION;
      addr_q      <= 12'h0;
      value_q     <= 32'h0;
      redirect_pc <= 32'h0;
      wait_cnt    <= '0;
    end else begin
      if (accept) begin
        op_q     <= arb_op;
        addr_q   <= cause_to_addr(arb_cause);
        value_q  <= trap_pc;
        wait_cnt <= '0;
      end else if (csr.csr_available && !timeout_hit) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (state == ST_WAIT && next_state == ST_REDIRECT) redirect_pc <= csr.csr_read_value;
    end
  end

  assign csr.csr_op             = op_q;
  assign csr.csr_addr_exception = addr_q;
  assign csr.csr_write_value    = value_q;

`ifdef TRAP_COUNT_EN
  logic [COUNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (state == ST_REDIRECT && op_q != CSR_OP_MRET && count_q != '1) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign trap_count = count_q;
`else
  assign trap_count = '0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: table of ops with a redirect scoreboard,
// plus hand sequences for boundary gating, timeout, fault and mid-op reset.
module tb_trap_sequencer;
  import trap_pkg::*;

  localparam int TO = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          exc_req, mret_req, int_boundary, ext_int_pending, sw_int_pending;
  logic [3:0]    exc_code;
  logic [31:0]   trap_pc;
  logic          ready, redirect_valid, seq_error;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] trap_count;

  trap_sequencer_if csr_bus ();

  trap_sequencer #(.TIMEOUT_CYCLES(TO), .COUNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .exc_req         (exc_req),
    .exc_code        (exc_code),
    .trap_pc         (trap_pc),
    .mret_req        (mret_req),
    .int_boundary    (int_boundary),
    .ext_int_pending (ext_int_pending),
    .sw_int_pending  (sw_int_pending),
    .csr             (csr_bus),
    .ready           (ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .seq_error       (seq_error),
    .trap_count      (trap_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic [3:0]  code;
    logic        ext;
    logic        sw;
    logic        bnd;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] ret;
    logic [2:0]  e_op;
    logic [11:0] e_addr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        is_trap;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;
  int   trap_model = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [CW-1:0] exp_count();
`ifdef TRAP_COUNT_EN
    return CW'(trap_model);
`else
    return '0;
`endif
  endfunction

  task automatic clear_reqs();
    exc_req = 1'b0; mret_req = 1'b0; ext_int_pending = 1'b0; sw_int_pending = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    trap_model = 0;
    check("rst_ready", ready, 1'b1);
    check("rst_error", seq_error, 1'b0);
    check("rst_avail", csr_bus.csr_available, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Accept at E0, CSR raises busy after E1, drops it with read_value after E2, redirect after E3.
  task automatic run_op(input string name, input vec_t v);
    exp_t e;
    @(negedge clk);
    exc_req = v.exc; exc_code = v.code; ext_int_pending = v.ext;
    sw_int_pending = v.sw; int_boundary = v.bnd; mret_req = v.mret; trap_pc = v.pc;
    check({name, "_ready"}, ready, 1'b1);
    sb.push_back('{pc: v.ret, is_trap: (v.e_op != CSR_OP_MRET)});
    @(negedge clk);
    clear_reqs();
    trap_pc = 32'hDEAD_BEEF;
    check({name, "_avail"}, csr_bus.csr_available, 1'b1);
    check({name, "_op"}, csr_bus.csr_op, v.e_op);
    check({name, "_addr"}, csr_bus.csr_addr_exception, v.e_addr);
    check({name, "_value"}, csr_bus.csr_write_value, v.pc);
    @(negedge clk);
    check({name, "_avail_e1"}, csr_bus.csr_available, 1'b1);
    csr_bus.csr_busy = 1'b1;
    @(negedge clk);
    check({name, "_early_redir"}, redirect_valid, 1'b0);
    csr_bus.csr_busy = 1'b0;
    csr_bus.csr_read_value = v.ret;
    @(negedge clk);
    csr_bus.csr_read_value = $urandom;
    check({name, "_redir"}, redirect_valid, 1'b1);
    check({name, "_avail_e3"}, csr_bus.csr_available, 1'b0);
    check({name, "_value_held"}, csr_bus.csr_write_value, v.pc);
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({name, "_redir_pc"}, redirect_pc, e.pc);
      if (e.is_trap && trap_model < (1 << CW) - 1) trap_model++;
    end
    @(negedge clk);
    check({name, "_pulse_end"}, redirect_valid, 1'b0);
    check({name, "_ready_e4"}, ready, 1'b1);
    check({name, "_count"}, trap_count, exp_count());
  endtask

  initial begin
    vec_t v;
    reset_n = 1'b0;
    clear_reqs();
    int_boundary = 1'b0; exc_code = 4'h0; trap_pc = 32'h0;
    csr_bus.csr_busy = 1'b0; csr_bus.csr_fault = 1'b0; csr_bus.csr_read_value = 32'h0;

    //            exc code  ext   sw    bnd   mret  pc            ret           op                addr
    vecs[0] = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0010, CSR_OP_EXCEPTION, 12'h002};
    vecs[1] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_2000, CSR_OP_MRET,      12'h000};
    vecs[2] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0400, 32'h0000_0500, CSR_OP_EXCEPTION, 12'h005};
    vecs[3] = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0404, 32'h0000_0600, CSR_OP_EXCEPTION, 12'h01B};
    vecs[4] = '{1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0408, 32'h0000_0700, CSR_OP_EXCEPTION, 12'h013};
    vecs[5] = '{1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_040C, 32'h0000_0800, CSR_OP_MRET,      12'h000};
    vecs[6] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0000_0900, CSR_OP_MRET,      12'h000};
    vecs[7] = '{1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 32'hABCD_0000, 32'h1234_5678, CSR_OP_EXCEPTION, 12'h00F};

    #2;
    check("reset_ready", ready, 1'b1);
    check("reset_avail", csr_bus.csr_available, 1'b0);
    check("reset_redir", redirect_valid, 1'b0);
    check("reset_error", seq_error, 1'b0);
    check("reset_pc", redirect_pc, 32'h0);
    check("reset_op", csr_bus.csr_op, 3'b000);
    check("reset_addr", csr_bus.csr_addr_exception, 12'h000);
    check("reset_value", csr_bus.csr_write_value, 32'h0);
    check("reset_count", trap_count, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;

    // External interrupt must wait for an instruction boundary.
    @(negedge clk);
    ext_int_pending = 1'b1;
    int_boundary    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_bnd_ready", ready, 1'b1);
      check("no_bnd_avail", csr_bus.csr_available, 1'b0);
    end
    v = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0040, CSR_OP_EXCEPTION, 12'h01B};
    run_op("bnd_ext", v);

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Timeout: busy never rises.
    @(negedge clk);
    exc_req = 1'b1; exc_code = 4'h3; int_boundary = 1'b0;
    @(negedge clk);
    clear_reqs();
    check("to_avail", csr_bus.csr_available, 1'b1);
    repeat (TO - 1) @(negedge clk);
    check("to_not_yet", seq_error, 1'b0);
    @(negedge clk);
    check("to_error", seq_error, 1'b1);
    check("to_ready", ready, 1'b0);
    check("to_avail_low", csr_bus.csr_available, 1'b0);
    exc_req = 1'b1;
    repeat (3) @(negedge clk);
    check("to_sticky", seq_error, 1'b1);
    check("to_no_redir", redirect_valid, 1'b0);
    check("to_still_busy", ready, 1'b0);
    clear_reqs();
    do_reset();
    check("to_count_clr", trap_count, 2'b00);

    // Fault during WAIT.
    @(negedge clk);
    mret_req = 1'b1;
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    csr_bus.csr_busy  = 1'b1;
    @(negedge clk);
    csr_bus.csr_fault = 1'b1;
    @(negedge clk);
    csr_bus.csr_fault = 1'b0;
    csr_bus.csr_busy  = 1'b0;
    check("fault_error", seq_error, 1'b1);
    check("fault_avail", csr_bus.csr_available, 1'b0);
    @(negedge clk);
    check("fault_no_redir", redirect_valid, 1'b0);
    do_reset();

    // Reset asserted while in WAIT aborts with no redirect.
    @(negedge clk);
    exc_req = 1'b1; exc_code = 4'h7;
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    csr_bus.csr_busy = 1'b1;
    @(negedge clk);
    check("mid_wait_avail", csr_bus.csr_available, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_avail", csr_bus.csr_available, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_redir", redirect_valid, 1'b0);
    check("mid_rst_addr", csr_bus.csr_addr_exception, 12'h000);
    csr_bus.csr_busy = 1'b0;
    csr_bus.csr_read_value = 32'h5555_5555;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_redir", redirect_valid, 1'b0);
      check("post_rst_pc", redirect_pc, 32'h0);
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
